ysyx_2022040010_div: RTL and testbench
======================================

Name: ysyx_2022040010_div

Overview:
- Multi-cycle RV64M divide unit in the EX stage; one bit per cycle (radix-2 restoring).
- Executes DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Drives stallreq_for_ex into the stall controller, which freezes IF/ID/EX while a division runs.
- The EX result mux takes result_o when done_o is high.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- div_valid_i  input  1  EX holds a divide op; stays high with stable operands while stalled.
- div_op_i  input  3  {word, rem, unsigned}; bit2=W form, bit1=remainder, bit0=unsigned.
- src1_i  input  XLEN  dividend.
- src2_i  input  XLEN  divisor.
- flush_i  input  1  branch/exception flush of EX; aborts the current operation.
- ex_hold_i  input  1  EX is held by another stall source (load, cache).
- stallreq_for_ex  output  1  EX stall request.
- done_o  output  1  result_o is valid this cycle.
- result_o  output  XLEN  quotient or remainder; W forms sign-extended from bit 31.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counter=0, done_o=0, result_o=0, stallreq_for_ex=0; all internal registers cleared.
- States: IDLE, CALC, DONE.
- stallreq_for_ex = div_valid_i & ~done_o & ~flush_i (combinational).
- Operand prep (combinational, in IDLE):
  - W forms use src[31:0]: sign-extended if signed, zero-extended if unsigned.
  - Signed forms divide absolute values. Record neg_q = sign1^sign2 and neg_r = sign1 (sign of the dividend).
- IDLE, div_valid_i=1, flush_i=0:
  - Divisor == 0: result = all-ones (quotient) or dividend (rem) → DONE.
  - Signed overflow (dividend = most-negative value of the op width, divisor = -1): quotient = dividend, rem = 0 → DONE.
  - Otherwise: load remainder=0 and quotient=|dividend|; counter = 32 for W forms, XLEN otherwise → CALC.
- IDLE, any other input: stay in IDLE.
- CALC, each cycle:
  - Shift {rem,quot} left by 1 and form the trial difference = rem_shifted − |divisor|.
  - If the trial is non-negative, rem = trial and quot LSB = 1; else quot LSB = 0.
  - counter decrements by 1. When counter reaches 1 this cycle → DONE.
- Entry to DONE (registered):
  - Apply negation per neg_q/neg_r.
  - Select quotient or remainder by op.
  - W forms: truncate to 32 bits and sign-extend to XLEN (DIVUW/REMUW included, per ISA).
  - Load result_o.
- DONE: done_o=1.
  - ex_hold_i=1: stay in DONE; result_o held stable.
  - ex_hold_i=0: → IDLE; done_o=0 next cycle.
- Latency, measured from the first cycle div_valid_i is seen in IDLE:
  - 64-bit op: done_o at cycle 65; stallreq_for_ex high cycles 0..64.
  - W op: done_o at cycle 33.
  - Special cases: done_o at cycle 1.
- flush_i=1 in any state: → IDLE next edge, done_o=0, no result delivered; stallreq_for_ex forced 0 that cycle. Flush has priority over ex_hold_i.
- After DONE→IDLE, a still-high div_valid_i is treated as a new operation (the next instruction); back-to-back divides need no idle bubble.
- Operand changes during CALC are ignored; operands are captured in IDLE.
- result_o keeps its last value in IDLE and CALC; only done_o qualifies it.
- Reset mid-CALC: immediate return to IDLE with all outputs 0.

Test Plan:
- DIVU src1=100, src2=7: stallreq_for_ex high 65 cycles, then done_o=1 with result_o=14. REMU same operands → 2.
- DIV src1=-7, src2=2 → -3 (0xFFFF_FFFF_FFFF_FFFD). REM same operands → -1. Done at cycle 65.
- DIVW src1=0x0000_0000_8000_0000, src2=-1 → overflow path, done at cycle 1, result 0xFFFF_FFFF_8000_0000. REMW same operands → 0.
- DIVU by zero, src1=5 → all-ones at cycle 1. REMU by zero → 5. DIVUW src1=0x1_0000_0005, src2=0 → 0xFFFF_FFFF_FFFF_FFFF.
- Start a DIV, assert flush_i at cycle 20: IDLE next cycle, done_o never rises. A new DIVU 9/3 issued afterwards returns 3 at cycle 65.
- Complete DIVU 50/5 with ex_hold_i=1 for 3 cycles at done: done_o stays high and result_o=10 stable for 4 cycles, then done_o falls. Also assert rst_n low mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_2022040010_div.sv
// Multi-cycle radix-2 restoring divider for the RV64M EX stage.
// Handles DIV/DIVU/REM/REMU and the W forms. Special cases (divide by zero,
// signed overflow) finish one cycle after issue; the rest iterate one
// quotient bit per cycle. The stall request holds the pipeline until done.
module ysyx_2022040010_div #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid_i,
    input  logic [2:0]      div_op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    input  logic            ex_hold_i,
    output logic            stallreq_for_ex,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quot_r;
    logic [XLEN-1:0]   dvs_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              word_r;
    logic              rem_sel_r;

    // Operand preparation
    logic              word_s, rem_s, uns_s;
    logic [XLEN-1:0]   op1_s, op2_s, abs1_s, abs2_s;
    logic              sign1_s, sign2_s;
    logic              dvs_zero_s, ovf_s, special_s;
    logic [XLEN-1:0]   special_raw_s;

    // Iteration datapath
    logic [XLEN:0]     rem_sh_s, trial_s;
    logic              ge_s;
    logic [XLEN-1:0]   rem_nx_s, quot_nx_s, q_fin_s, r_fin_s, calc_res_s;

    // W-form results are truncated to 32 bits and sign-extended, unsigned forms included.
    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] val, input logic word);
        logic [XLEN-1:0] res;
        if (word) begin
            res = {{(XLEN-32){val[31]}}, val[31:0]};
        end else begin
            res = val;
        end
        return res;
    endfunction

    assign word_s = div_op_i[2];
    assign rem_s  = div_op_i[1];
    assign uns_s  = div_op_i[0];

    // Stall while a divide is outstanding; a flush or reset releases it immediately.
    assign stallreq_for_ex = div_valid_i & ~done_o & ~flush_i & rst_n;

    // Extend operands for the op width, take magnitudes and detect special cases.
    always_comb begin
        if (word_s) begin
            if (uns_s) begin
                op1_s = {{(XLEN-32){1'b0}}, src1_i[31:0]};
                op2_s = {{(XLEN-32){1'b0}}, src2_i[31:0]};
            end else begin
                op1_s = {{(XLEN-32){src1_i[31]}}, src1_i[31:0]};
                op2_s = {{(XLEN-32){src2_i[31]}}, src2_i[31:0]};
            end
        end else begin
            op1_s = src1_i;
            op2_s = src2_i;
        end
        sign1_s = ~uns_s & op1_s[XLEN-1];
        sign2_s = ~uns_s & op2_s[XLEN-1];
        abs1_s  = sign1_s ? (~op1_s + {{(XLEN-1){1'b0}}, 1'b1}) : op1_s;
        abs2_s  = sign2_s ? (~op2_s + {{(XLEN-1){1'b0}}, 1'b1}) : op2_s;
        dvs_zero_s = (op2_s == {XLEN{1'b0}});
        if (word_s) begin
            ovf_s = ~uns_s & (op1_s == {{(XLEN-31){1'b1}}, {31{1'b0}}}) & (op2_s == {XLEN{1'b1}});
        end else begin
            ovf_s = ~uns_s & (op1_s == {1'b1, {(XLEN-1){1'b0}}}) & (op2_s == {XLEN{1'b1}});
        end
        special_s = dvs_zero_s | ovf_s;
        if (dvs_zero_s) begin
            special_raw_s = rem_s ? op1_s : {XLEN{1'b1}};
        end else begin
            special_raw_s = rem_s ? {XLEN{1'b0}} : op1_s;
        end
    end

    // One restoring step plus sign fix-up and result selection for the final step.
    always_comb begin
        rem_sh_s  = {rem_r, quot_r[XLEN-1]};
        trial_s   = rem_sh_s - {1'b0, dvs_r};
        ge_s      = ~trial_s[XLEN];
        rem_nx_s  = ge_s ? trial_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
        quot_nx_s = {quot_r[XLEN-2:0], ge_s};
        q_fin_s   = neg_q_r ? (~quot_nx_s + {{(XLEN-1){1'b0}}, 1'b1}) : quot_nx_s;
        r_fin_s   = neg_r_r ? (~rem_nx_s + {{(XLEN-1){1'b0}}, 1'b1}) : rem_nx_s;
        calc_res_s = word_fix(rem_sel_r ? r_fin_s : q_fin_s, word_r);
    end

    // Next-state logic; flush wins over everything, including ex_hold_i.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_valid_i && !flush_i) begin
                    state_nx_s = special_s ? DONE : CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_nx_s = IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            DONE: begin
                if (flush_i) begin
                    state_nx_s = IDLE;
                end else if (ex_hold_i) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, iteration registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quot_r    <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            word_r    <= 1'b0;
            rem_sel_r <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= {XLEN{1'b0}};
        end else begin
            done_o <= (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (div_valid_i && !flush_i) begin
                        word_r    <= word_s;
                        rem_sel_r <= rem_s;
                        neg_q_r   <= sign1_s ^ sign2_s;
                        neg_r_r   <= sign1_s;
                        if (special_s) begin
                            result_o <= word_fix(special_raw_s, word_s);
                        end else begin
                            rem_r <= {XLEN{1'b0}};
                            if (word_s) begin
                                // Dividend sits in the top half so its bits shift out first.
                                quot_r <= {abs1_s[31:0], {(XLEN-32){1'b0}}};
                                dvs_r  <= {{(XLEN-32){1'b0}}, abs2_s[31:0]};
                                cnt_r  <= CNT_W'(32);
                            end else begin
                                quot_r <= abs1_s;
                                dvs_r  <= abs2_s;
                                cnt_r  <= CNT_W'(XLEN);
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        rem_r  <= rem_nx_s;
                        quot_r <= quot_nx_s;
                        cnt_r  <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            result_o <= calc_res_s;
                        end else begin
                            result_o <= result_o;
                        end
                    end else begin
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_div.sv
// Directed self-checking bench for the radix-2 divider.
module tb_ysyx_2022040010_div;

    logic        clk;
    logic        rst_n;
    logic        div_valid_i;
    logic [2:0]  div_op_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        ex_hold_i;
    logic        stallreq_for_ex;
    logic        done_o;
    logic [63:0] result_o;

    int n_chk;
    int n_fail;

    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_REM   = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVW  = 3'b100;
    localparam logic [2:0] OP_DIVUW = 3'b101;
    localparam logic [2:0] OP_REMW  = 3'b110;

    ysyx_2022040010_div #(.XLEN(64), .CNT_W(7)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .div_valid_i     (div_valid_i),
        .div_op_i        (div_op_i),
        .src1_i          (src1_i),
        .src2_i          (src2_i),
        .flush_i         (flush_i),
        .ex_hold_i       (ex_hold_i),
        .stallreq_for_ex (stallreq_for_ex),
        .done_o          (done_o),
        .result_o        (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Present an op; the current cycle becomes cycle 0.
    task automatic start(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        div_valid_i = 1'b1;
        div_op_i    = op;
        src1_i      = a;
        src2_i      = b;
        #1;
    endtask

    // Count cycles from cycle 0 until done_o, checking stall, latency and result.
    task automatic wait_done(input int exp_lat, input logic [63:0] exp_res, input string name);
        int cyc;
        bit stall_ok;
        cyc = 0;
        stall_ok = 1'b1;
        n_chk++;
        if (stallreq_for_ex !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cycle0: stall=%b done=%b, required stall=1 done=0", name, stallreq_for_ex, done_o);
        end
        while (cyc < 200) begin
            next_cycle();
            cyc++;
            if (done_o === 1'b1) break;
            if (stallreq_for_ex !== 1'b1) stall_ok = 1'b0;
        end
        n_chk++;
        if (cyc != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", name, cyc, exp_lat);
        end
        n_chk++;
        if (!stall_ok) begin
            n_fail++;
            $display("FAIL %s stall: stallreq dropped before done", name);
        end
        n_chk++;
        if (result_o !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", name, result_o, exp_res);
        end
        n_chk++;
        if (stallreq_for_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall_at_done: got %b, required 0", name, stallreq_for_ex);
        end
    endtask

    // Drop valid after done and check done_o falls one cycle later.
    task automatic finish_op(input string name);
        div_valid_i = 1'b0;
        next_cycle();
        n_chk++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_fall: got %b, required 0", name, done_o);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input logic [63:0] res, input string name);
        start(op, a, b);
        wait_done(lat, res, name);
        finish_op(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (done_o !== 1'b0 || result_o !== 64'd0 || stallreq_for_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: done=%b result=%h stall=%b, required 0/0/0", done_o, result_o, stallreq_for_ex);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_unsigned();
        run_op(OP_DIVU, 64'd100, 64'd7, 65, 64'd14, "divu_100_7");
        run_op(OP_REMU, 64'd100, 64'd7, 65, 64'd2, "remu_100_7");
    endtask

    task automatic test_signed();
        run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
        run_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
    endtask

    task automatic test_word();
        run_op(OP_DIVW, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFA, "divw_m20_3");
        run_op(OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF, "divuw_ffffffff_1");
    endtask

    task automatic test_overflow();
        run_op(OP_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
        run_op(OP_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, "remw_ovf");
    endtask

    task automatic test_div_zero();
        run_op(OP_DIVU, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, "divu_zero");
        run_op(OP_REMU, 64'd5, 64'd0, 1, 64'd5, "remu_zero");
        run_op(OP_DIVUW, 64'h0000_0001_0000_0005, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, "divuw_zero");
    endtask

    task automatic test_flush();
        bit seen_done;
        start(OP_DIV, 64'd100, 64'd7);
        for (int i = 0; i < 20; i++) next_cycle();
        flush_i = 1'b1;
        #1;
        n_chk++;
        if (stallreq_for_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b, required 0", stallreq_for_ex);
        end
        next_cycle();
        flush_i     = 1'b0;
        div_valid_i = 1'b0;
        seen_done   = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (done_o === 1'b1) seen_done = 1'b1;
            next_cycle();
        end
        n_chk++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL flush_no_done: done_o rose after flush, required never");
        end
        run_op(OP_DIVU, 64'd9, 64'd3, 65, 64'd3, "divu_after_flush");
    endtask

    task automatic test_hold();
        start(OP_DIVU, 64'd50, 64'd5);
        wait_done(65, 64'd10, "divu_hold");
        ex_hold_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            n_chk++;
            if (done_o !== 1'b1 || result_o !== 64'd10) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: done=%b result=%h, required 1 and 000000000000000a", i, done_o, result_o);
            end
        end
        ex_hold_i = 1'b0;
        finish_op("divu_hold");
    endtask

    task automatic test_back_to_back();
        start(OP_DIVU, 64'd100, 64'd7);
        wait_done(65, 64'd14, "b2b_first");
        div_op_i = OP_REMU;
        next_cycle();
        n_chk++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: done=%b, required 0", done_o);
        end
        wait_done(65, 64'd2, "b2b_second");
        finish_op("b2b_second");
    endtask

    task automatic test_reset_mid_calc();
        start(OP_DIVU, 64'd100, 64'd7);
        for (int i = 0; i < 10; i++) next_cycle();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (done_o !== 1'b0 || result_o !== 64'd0 || stallreq_for_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: done=%b result=%h stall=%b, required 0/0/0", done_o, result_o, stallreq_for_ex);
        end
        div_valid_i = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run_op(OP_DIVU, 64'd9, 64'd3, 65, 64'd3, "divu_after_reset");
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        div_valid_i = 1'b0;
        div_op_i    = 3'b000;
        src1_i      = 64'd0;
        src2_i      = 64'd0;
        flush_i     = 1'b0;
        ex_hold_i   = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_word();
        test_overflow();
        test_div_zero();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
